// File: rtl/gate_seq_pkg.sv
// Shared types, constants and golden model for the gate vector sequencer.
// Gate bit order, bit 0 first: and, or, nand, nor, xor, xnor, not.
package gate_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      DONE
   } state_t;

   localparam int NUM_VEC   = 4;
   localparam int NUM_GATES = 7;

   localparam int GATE_AND  = 0;
   localparam int GATE_OR   = 1;
   localparam int GATE_NAND = 2;
   localparam int GATE_NOR  = 3;
   localparam int GATE_XOR  = 4;
   localparam int GATE_XNOR = 5;
   localparam int GATE_NOT  = 6;

   function automatic logic [NUM_GATES-1:0] golden(
      input logic a,
      input logic b
   );
      logic [NUM_GATES-1:0] g;
      g            = '0;
      g[GATE_AND]  = a & b;
      g[GATE_OR]   = a | b;
      g[GATE_NAND] = ~(a & b);
      g[GATE_NOR]  = ~(a | b);
      g[GATE_XOR]  = a ^ b;
      g[GATE_XNOR] = ~(a ^ b);
      g[GATE_NOT]  = ~a;
      return g;
   endfunction

endpackage

// File: rtl/gate_vector_sequencer_compare.sv
// Combinational check of the seven gate responses against the golden model.
// Ports: a/b stimulus, seven gate outputs in; mismatch mask, any_mismatch out.
module gate_response_compare
   import gate_seq_pkg::*;
(
   input  logic                 a,
   input  logic                 b,
   input  logic                 out_and,
   input  logic                 out_or,
   input  logic                 out_nand,
   input  logic                 out_nor,
   input  logic                 out_xor,
   input  logic                 out_xnor,
   input  logic                 out_not,
   output logic [NUM_GATES-1:0] mismatch,
   output logic                 any_mismatch
);

   logic [NUM_GATES-1:0] resp;

   always_comb begin
      resp            = '0;
      resp[GATE_AND]  = out_and;
      resp[GATE_OR]   = out_or;
      resp[GATE_NAND] = out_nand;
      resp[GATE_NOR]  = out_nor;
      resp[GATE_XOR]  = out_xor;
      resp[GATE_XNOR] = out_xnor;
      resp[GATE_NOT]  = out_not;
   end

   assign mismatch     = resp ^ golden(a, b);
   assign any_mismatch = |mismatch;

endmodule

// File: rtl/gate_vector_sequencer.sv
// Sweeps a/b through 00,01,10,11, checks gate responses, reports pass/fail.
// Ports: clk, rst_n, start in; a, b, busy, sample, done, pass, results out.
module gate_vector_sequencer
   import gate_seq_pkg::*;
#(
   parameter int DWELL  = 10,
   parameter int PASSES = 1,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a,
   output logic             b,
   input  logic             out_and,
   input  logic             out_or,
   input  logic             out_nand,
   input  logic             out_nor,
   input  logic             out_xor,
   input  logic             out_xnor,
   input  logic             out_not,
   output logic             busy,
   output logic             sample,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [1:0]       fail_vec,
   output logic [6:0]       fail_mask
);

   localparam int DW = $clog2(DWELL);
   localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

   state_t          state;
   state_t          state_nxt;
   logic [1:0]      vec;
   logic [DW-1:0]   dcnt;
   logic [PW-1:0]   pcnt;
   logic            first_seen;
   logic [6:0]      mismatch;
   logic            any_mismatch;
   logic            at_end;
   logic            last_vec;
   logic            last_pass;
   logic            begin_run;

   gate_response_compare u_cmp (
      .a            (a),
      .b            (b),
      .out_and      (out_and),
      .out_or       (out_or),
      .out_nand     (out_nand),
      .out_nor      (out_nor),
      .out_xor      (out_xor),
      .out_xnor     (out_xnor),
      .out_not      (out_not),
      .mismatch     (mismatch),
      .any_mismatch (any_mismatch)
   );

   // The vector index is the stimulus itself: {a,b} = vec.
   assign {a, b}    = vec;
   assign busy      = (state == DRIVE);
   assign at_end    = busy && (dcnt == DW'(DWELL - 1));
   assign sample    = at_end;
   assign last_vec  = (vec == 2'(NUM_VEC - 1));
   assign last_pass = (pcnt == PW'(PASSES - 1));
   assign begin_run = start && (state != DRIVE);
   assign done      = (state == DONE);
   assign pass      = done && (err_count == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (start) state_nxt = DRIVE;
         DRIVE: if (at_end && last_vec && last_pass) state_nxt = DONE;
         DONE:  if (start) state_nxt = DRIVE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec        <= '0;
         dcnt       <= '0;
         pcnt       <= '0;
         err_count  <= '0;
         fail_vec   <= '0;
         fail_mask  <= '0;
         first_seen <= 1'b0;
      end else if (begin_run) begin
         vec        <= '0;
         dcnt       <= '0;
         pcnt       <= '0;
         err_count  <= '0;
         fail_vec   <= '0;
         fail_mask  <= '0;
         first_seen <= 1'b0;
      end else if (busy) begin
         if (at_end) begin
            dcnt <= '0;
            // Wraps 11 -> 00, which also parks {a,b} at 00 in DONE.
            vec  <= vec + 2'd1;
            if (last_vec) pcnt <= pcnt + PW'(1);
            if (any_mismatch) begin
               if (err_count != '1) err_count <= err_count + ERR_W'(1);
               if (!first_seen) begin
                  first_seen <= 1'b1;
                  fail_vec   <= vec;
                  fail_mask  <= mismatch;
               end
            end
         end else begin
            dcnt <= dcnt + DW'(1);
         end
      end
   end

endmodule
